prange: RTL and testbench

PRANGE -- requirements
Module: prange

---
 rtl/prange_pkg.sv | 13 +
 rtl/prange_lane.sv | 40 ++++
 rtl/prange.sv | 129 ++++++++++++
 tb/tb_prange.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prange_pkg.sv
// Shared types for the prange range generator.
// Holds the FSM encoding and the lane-count ceiling.
package prange_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam int MAX_LANES = 8;

endpackage

// File: rtl/prange_lane.sv
// One output lane: value = lane0 + K*step, plus its in-range flag.
// Arithmetic runs at EXT bits so a wrapped sum can never look in range.
module prange_lane #(
  parameter int WIDTH = 32,
  parameter int EXT   = 36,
  parameter int K     = 0
) (
  input  logic [EXT-1:0]   lane0,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] value,
  output logic             hit
);

  logic signed [EXT-1:0] sx;
  logic signed [EXT-1:0] lx;
  logic signed [EXT-1:0] kx;
  logic signed [EXT-1:0] vx;
  logic                  pos;
  logic                  neg;

  assign sx  = {{(EXT-WIDTH){step[WIDTH-1]}}, step};
  assign lx  = {{(EXT-WIDTH){limit[WIDTH-1]}}, limit};
  assign kx  = EXT'(K);
  assign vx  = $signed(lane0) + sx * kx;
  assign neg = sx[EXT-1];
  assign pos = !neg && (sx != '0);

  always_comb begin
    hit = 1'b0;
    unique case (1'b1)
      pos:     hit = vx < lx;
      neg:     hit = vx > lx;
      default: hit = 1'b0;
    endcase
  end

  assign value = vx[WIDTH-1:0];

endmodule

// File: rtl/prange.sv
// Streams base, base+step, ... up to (not including) limit,
// LANES values per beat over a valid/ready handshake.
module prange
  import prange_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 2
) (
  input  logic                   _clock,
  input  logic                   _reset,
  input  logic                   _start,
  input  logic                   _ready,
  input  logic [WIDTH-1:0]       base,
  input  logic [WIDTH-1:0]       limit,
  input  logic [WIDTH-1:0]       step,
  output logic                   _valid,
  output logic                   _done,
  output logic [LANES-1:0]       _lanes,
  output logic [LANES*WIDTH-1:0] _out,
  output logic [WIDTH-1:0]       _index
);

  localparam int EXT = WIDTH + 4;

  if (LANES < 1 || LANES > MAX_LANES) begin : g_bad
    $error("prange: LANES out of range");
  end

  state_t state;
  state_t state_n;

  logic signed [EXT-1:0] acc;
  logic [WIDTH-1:0]      stp;
  logic [WIDTH-1:0]      lim;
  logic [WIDTH-1:0]      idx;

  logic signed [EXT-1:0] bx;
  logic signed [EXT-1:0] sx_in;
  logic signed [EXT-1:0] lx_in;
  logic signed [EXT-1:0] sx;
  logic signed [EXT-1:0] lx;
  logic signed [EXT-1:0] lanes_x;
  logic signed [EXT-1:0] nxt;
  logic                  nxt_in;
  logic                  start_ok;
  logic                  run;
  logic                  xfer;
  logic                  load;

  assign bx      = {{(EXT-WIDTH){base[WIDTH-1]}}, base};
  assign sx_in   = {{(EXT-WIDTH){step[WIDTH-1]}}, step};
  assign lx_in   = {{(EXT-WIDTH){limit[WIDTH-1]}}, limit};
  assign sx      = {{(EXT-WIDTH){stp[WIDTH-1]}}, stp};
  assign lx      = {{(EXT-WIDTH){lim[WIDTH-1]}}, lim};
  assign lanes_x = EXT'(LANES);
  assign nxt     = acc + sx * lanes_x;

  // Zero step falls through both terms, so it is an empty range.
  assign start_ok = (sx_in > 0 && bx < lx_in)
                 || (sx_in < 0 && bx > lx_in);
  assign nxt_in   = (sx > 0 && nxt < lx)
                 || (sx < 0 && nxt > lx);

  assign run  = state == S_RUN;
  assign xfer = run && _ready;
  assign load = !run && _start;

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (_start) state_n = start_ok ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (_ready && !nxt_in) state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      acc <= '0;
      stp <= '0;
      lim <= '0;
      idx <= '0;
    end else if (load) begin
      acc <= bx;
      stp <= step;
      lim <= limit;
      idx <= '0;
    end else if (xfer && nxt_in) begin
      acc <= nxt;
      idx <= idx + WIDTH'(LANES);
    end
  end

  logic [WIDTH-1:0] val [LANES];
  logic [LANES-1:0] hit;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    prange_lane #(
      .WIDTH (WIDTH),
      .EXT   (EXT),
      .K     (k)
    ) u_lane (
      .lane0 (acc),
      .step  (stp),
      .limit (lim),
      .value (val[k]),
      .hit   (hit[k])
    );
    assign _lanes[k] = run && hit[k];
    assign _out[k*WIDTH +: WIDTH] = _lanes[k] ? val[k] : '0;
  end

  assign _valid = run;
  assign _done  = state == S_DONE;
  assign _index = idx;

endmodule

// File: tb/tb_prange.sv
// Scoreboard bench for prange: stimulus queues beats, monitors check.
// A 32-bit and an 8-bit instance are exercised.
module tb_prange;

  typedef struct {
    bit          fin;
    logic [31:0] o0;
    logic [31:0] o1;
    logic [1:0]  m;
    logic [31:0] ix;
  } exp_t;

  logic clk = 0;
  logic rst_n;
  logic rdy;

  logic        st32;
  logic [31:0] b32, l32, s32;
  logic        v32, d32;
  logic [1:0]  m32;
  logic [63:0] o32;
  logic [31:0] i32;

  logic        st8;
  logic [7:0]  b8, l8, s8;
  logic        v8, d8;
  logic [1:0]  m8;
  logic [15:0] o8;
  logic [7:0]  i8;

  exp_t q32[$];
  exp_t q8[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prange u32 (
    ._clock (clk), ._reset (rst_n),
    ._start (st32), ._ready (rdy),
    .base (b32), .limit (l32), .step (s32),
    ._valid (v32), ._done (d32), ._lanes (m32),
    ._out (o32), ._index (i32)
  );

  prange #(.WIDTH(8), .LANES(2)) u8 (
    ._clock (clk), ._reset (rst_n),
    ._start (st8), ._ready (rdy),
    .base (b8), .limit (l8), .step (s8),
    ._valid (v8), ._done (d8), ._lanes (m8),
    ._out (o8), ._index (i8)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void beat32(input logic [31:0] a, b,
                                 input logic [1:0] m,
                                 input logic [31:0] ix);
    q32.push_back('{1'b0, a, b, m, ix});
  endfunction

  function automatic void fin32();
    q32.push_back('{1'b1, 32'd0, 32'd0, 2'd0, 32'd0});
  endfunction

  task automatic mon_beat(input string nm, input exp_t e,
                          input logic [31:0] a, b,
                          input logic [1:0] m,
                          input logic [31:0] ix);
    chk({nm, " kind"}, 64'(e.fin), 64'd0);
    chk({nm, " lane0"}, 64'(a), 64'(e.o0));
    chk({nm, " lane1"}, 64'(b), 64'(e.o1));
    chk({nm, " mask"}, 64'(m), 64'(e.m));
    chk({nm, " index"}, 64'(ix), 64'(e.ix));
  endtask

  logic d32_q = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      d32_q = 0;
    end else begin
      if (v32) begin
        if (q32.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat32 got valid want none");
        end else begin
          e = q32[0];
          mon_beat("beat32", e, o32[31:0], o32[63:32],
                   m32, i32);
          if (rdy) void'(q32.pop_front());
        end
      end
      if (d32 && !d32_q) begin
        if (q32.size() == 0) begin
          checks++; errors++;
          $display("FAIL done32 got done want none");
        end else begin
          e = q32.pop_front();
          chk("done32 marker", 64'(e.fin), 64'd1);
        end
      end
      d32_q = d32;
    end
  end

  logic d8_q = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      d8_q = 0;
    end else begin
      if (v8) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat8 got valid want none");
        end else begin
          e = q8[0];
          mon_beat("beat8", e, 32'(o8[7:0]), 32'(o8[15:8]),
                   m8, 32'(i8));
          if (rdy) void'(q8.pop_front());
        end
      end
      if (d8 && !d8_q) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL done8 got done want none");
        end else begin
          e = q8.pop_front();
          chk("done8 marker", 64'(e.fin), 64'd1);
        end
      end
      d8_q = d8;
    end
  end

  task automatic go32(input logic [31:0] b, l, s);
    @(posedge clk); #1;
    st32 = 1; b32 = b; l32 = l; s32 = s;
    @(posedge clk); #1;
    st32 = 0;
  endtask

  task automatic go8(input logic [7:0] b, l, s);
    @(posedge clk); #1;
    st8 = 1; b8 = b; l8 = l; s8 = s;
    @(posedge clk); #1;
    st8 = 0;
  endtask

  task automatic drain(input string nm, input bit wide);
    for (int i = 0; i < 40; i++) begin
      if ((wide ? q32.size() : q8.size()) == 0) break;
      @(posedge clk);
    end
    chk({nm, " drained"},
        64'(wide ? q32.size() : q8.size()), 64'd0);
  endtask

  task automatic zero32(input string nm);
    chk({nm, " valid"}, 64'(v32), 64'd0);
    chk({nm, " done"}, 64'(d32), 64'd0);
    chk({nm, " lanes"}, 64'(m32), 64'd0);
    chk({nm, " out"}, o32, 64'd0);
    chk({nm, " index"}, 64'(i32), 64'd0);
  endtask

  initial begin
    rst_n = 0; rdy = 1;
    st32 = 0; b32 = 0; l32 = 0; s32 = 0;
    st8 = 0; b8 = 0; l8 = 0; s8 = 0;
    #3;
    zero32("reset");
    chk("reset8 valid", 64'(v8), 64'd0);
    chk("reset8 out", 64'(o8), 64'd0);
    #9 rst_n = 1;

    fin32();
    go32(32'd5, 32'd5, 32'd1);
    chk("empty eq done", 64'(d32), 64'd1);
    chk("empty eq valid", 64'(v32), 64'd0);
    drain("empty eq", 1);

    go32(32'd0, 32'd10, 32'd0);
    chk("zero step done", 64'(d32), 64'd1);
    chk("zero step valid", 64'(v32), 64'd0);
    repeat (3) @(posedge clk);

    beat32(1, 4, 2'b11, 0);
    beat32(7, 10, 2'b11, 2);
    fin32();
    go32(32'd1, 32'd11, 32'd3);
    drain("r1_11_3", 1);

    beat32(0, 4, 2'b11, 0);
    beat32(8, 0, 2'b01, 2);
    fin32();
    go32(32'd0, 32'd10, 32'd4);
    drain("r0_10_4", 1);

    beat32(10, 7, 2'b11, 0);
    beat32(4, 1, 2'b11, 2);
    fin32();
    go32(32'd10, 32'd0, -32'sd3);
    drain("r10_0_m3", 1);

    beat32(0, 2, 2'b11, 0);
    beat32(4, 6, 2'b11, 2);
    beat32(8, 0, 2'b01, 4);
    fin32();
    go32(32'd0, 32'd10, 32'd2);
    @(posedge clk); #1;
    rdy = 0;
    @(posedge clk); #1;
    st32 = 1; b32 = 100; l32 = 200; s32 = 7;
    @(posedge clk); #1;
    st32 = 0;
    @(posedge clk); #1;
    rdy = 1;
    drain("stall", 1);

    rdy = 0;
    beat32(0, 1, 2'b11, 0);
    go32(32'd0, 32'd100, 32'd1);
    @(posedge clk); #3;
    rst_n = 0;
    q32.delete();
    #1;
    zero32("async rst");
    #2 rst_n = 1;
    rdy = 1;
    repeat (2) @(posedge clk);
    #1;
    zero32("post rst idle");
    beat32(0, 1, 2'b11, 0);
    beat32(2, 3, 2'b11, 2);
    fin32();
    go32(32'd0, 32'd4, 32'd1);
    drain("r0_4_1", 1);

    q8.push_back('{1'b0, 32'd120, 32'd125, 2'b11, 32'd0});
    q8.push_back('{1'b1, 32'd0, 32'd0, 2'd0, 32'd0});
    go8(8'd120, 8'd127, 8'd5);
    drain("w8", 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
